// File: rtl/envelope_vca_if.sv
`default_nettype none
// ============================================================================
// Module   : envelope_vca_if
// Purpose  : Gate/oscillator inputs and envelope/PWM outputs of the voice VCA
// Revision : 1.0
// ============================================================================
interface envelope_vca_if;
    logic       gate;
    logic       osc_in;
    logic       pwmout;
    logic [7:0] env_level;
    logic [2:0] env_state;
    logic       active;

    modport master (
        output gate,
        output osc_in,
        input  pwmout,
        input  env_level,
        input  env_state,
        input  active
    );

    modport slave (
        input  gate,
        input  osc_in,
        output pwmout,
        output env_level,
        output env_state,
        output active
    );
endinterface
`default_nettype wire

// File: rtl/envelope_vca.sv
`default_nettype none
// ============================================================================
// Module   : envelope_vca
// Purpose  : ADSR amplitude envelope driving a PWM-gated one-bit oscillator
// Revision : 1.0
// ============================================================================
module envelope_vca #(
    parameter int unsigned TICK_DIV      = 12,
    parameter int unsigned ATTACK_STEP   = 8,
    parameter int unsigned DECAY_STEP    = 2,
    parameter int unsigned SUSTAIN_LEVEL = 160,
    parameter int unsigned RELEASE_STEP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    envelope_vca_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [8:0]          c_attack_step  = 9'(ATTACK_STEP);
    localparam logic [8:0]          c_decay_step   = 9'(DECAY_STEP);
    localparam logic [8:0]          c_release_step = 9'(RELEASE_STEP);
    localparam logic [7:0]          c_sustain      = 8'(SUSTAIN_LEVEL);
    localparam logic [TICK_DIV-1:0] c_presc_one    = TICK_DIV'(1);

    state_t              state_q, state_d;
    logic [7:0]          level_q, level_d;
    logic [TICK_DIV-1:0] presc_q, presc_d;
    logic [7:0]          pwm_cnt_q, pwm_cnt_d;
    logic                pwmout_q, pwmout_d;
    logic                g1_q, g1_d, g2_q, g2_d, g3_q, g3_d;
    logic [1:0]          arm_q, arm_d;

    logic       tick, edge_ok, rise, fall;
    logic [8:0] att_sum, dec_diff, rel_diff;

    // Edges are only trusted once g3 holds a post-reset gate sample, so a gate
    // held high through reset release is not mistaken for a new note.
    assign edge_ok = (arm_q == 2'd3);
    assign rise    = edge_ok & g2_q & ~g3_q;
    assign fall    = edge_ok & ~g2_q & g3_q;
    assign tick    = &presc_q;

    always_comb begin
        g1_d      = bus.gate;
        g2_d      = g1_q;
        g3_d      = g2_q;
        arm_d     = edge_ok ? arm_q : arm_q + 2'd1;
        presc_d   = presc_q + c_presc_one;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwmout_d  = bus.osc_in & (pwm_cnt_q < level_q);
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        att_sum  = {1'b0, level_q} + c_attack_step;
        dec_diff = {1'b0, level_q} - c_decay_step;
        rel_diff = {1'b0, level_q} - c_release_step;
        // An edge always takes priority over a tick: no level step that cycle.
        case (state_q)
            ST_IDLE: begin
                level_d = 8'd0;
                if (rise) state_d = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (tick && !rise) begin
                    if (att_sum >= 9'd255) begin
                        level_d = 8'd255;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = att_sum[7:0];
                    end
                end
            end
            ST_DECAY: begin
                if (fall) begin
                    state_d = ST_RELEASE;
                end else if (rise) begin
                    state_d = ST_ATTACK;
                end else if (tick) begin
                    if (dec_diff[8] || (dec_diff <= {1'b0, c_sustain})) begin
                        level_d = c_sustain;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = dec_diff[7:0];
                    end
                end
            end
            ST_SUSTAIN: begin
                level_d = c_sustain;
                if (fall)      state_d = ST_RELEASE;
                else if (rise) state_d = ST_ATTACK;
            end
            ST_RELEASE: begin
                if (rise) begin
                    state_d = ST_ATTACK;
                end else if (tick && !fall) begin
                    if (rel_diff[8] || (rel_diff == 9'd0)) begin
                        level_d = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = rel_diff[7:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            level_q   <= 8'd0;
            presc_q   <= '0;
            pwm_cnt_q <= 8'd0;
            pwmout_q  <= 1'b0;
            g1_q      <= 1'b0;
            g2_q      <= 1'b0;
            g3_q      <= 1'b0;
            arm_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwmout_q  <= pwmout_d;
            g1_q      <= g1_d;
            g2_q      <= g2_d;
            g3_q      <= g3_d;
            arm_q     <= arm_d;
        end
    end

    assign bus.pwmout    = pwmout_q;
    assign bus.env_level = level_q;
    assign bus.env_state = state_q;
    assign bus.active    = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_envelope_vca.sv
`default_nettype none
// ============================================================================
// Module   : tb_envelope_vca
// Purpose  : Scoreboard bench for envelope_vca state/level trajectory and PWM
// Revision : 1.0
// ============================================================================
module tb_envelope_vca;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    envelope_vca_if bus1();
    envelope_vca_if bus2();

    envelope_vca #(.TICK_DIV(2), .ATTACK_STEP(64), .DECAY_STEP(16),
                   .SUSTAIN_LEVEL(128), .RELEASE_STEP(32))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Second voice with full-scale sustain to hold level 255 for the duty check.
    envelope_vca #(.TICK_DIV(2), .ATTACK_STEP(64), .DECAY_STEP(16),
                   .SUSTAIN_LEVEL(255), .RELEASE_STEP(32))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int          total = 0;
    int          bad   = 0;
    int          n, cnt, viol;
    logic [10:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [10:0] mon_prev, mon_cur, mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int st, input int lv);
        exp_q.push_back({3'(st), 8'(lv)});
    endtask

    task automatic push_note_to_sustain();
        push(1, 0);
        push(1, 64);
        push(1, 128);
        push(1, 192);
        push(2, 255);
        for (int l = 239; l >= 143; l -= 16) push(2, l);
        push(3, 128);
    endtask

    task automatic wait1(input int st, input int lv, input int budget, input string name);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus1.env_state == 3'(st) && bus1.env_level == 8'(lv)) && n < budget);
        check(name, {bus1.env_state, bus1.env_level}, {3'(st), 8'(lv)});
    endtask

    // Monitor: every change of {state, level} must match the next queued entry.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cur = {bus1.env_state, bus1.env_level};
            if (mon_cur !== mon_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got 0x%0h required no change from 0x%0h",
                             mon_cur, mon_prev);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_transition", mon_cur, mon_exp);
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        bus1.gate = 1'b0; bus1.osc_in = 1'b1;
        bus2.gate = 1'b0; bus2.osc_in = 1'b1;

        // Reset asserted between edges must clear outputs at once.
        #2 rst = 1'b0;
        #1;
        check("rst_level",  bus1.env_level, 0);
        check("rst_state",  bus1.env_state, 0);
        check("rst_active", bus1.active, 0);
        check("rst_pwmout", bus1.pwmout, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mon_prev = 11'd0;
        mon_en   = 1'b1;

        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus1.env_level != 8'd0 || bus1.env_state != 3'd0 ||
                bus1.active !== 1'b0 || bus1.pwmout !== 1'b0) viol++;
        end
        check("idle_hold", viol, 0);

        // Attack / decay / sustain
        @(posedge clk); #1 bus1.gate = 1'b1;
        push_note_to_sustain();
        @(posedge clk);
        @(posedge clk); #1 check("attack_not_early", bus1.env_state, 0);
        @(posedge clk); #1 check("attack_after_2",   bus1.env_state, 1);
        wait1(3, 128, 200, "reach_sustain");
        repeat (4) @(negedge clk);
        check("sb_drained_sustain", exp_q.size(), 0);

        cnt = 0;
        repeat (256) begin @(negedge clk); cnt += int'(bus1.pwmout); end
        check("pwm_duty_128", cnt, 128);

        // Full-scale sustain: DECAY ends on its first tick
        @(posedge clk); #1 bus2.gate = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus2.env_state != 3'd2 && n < 100);
        check("dut2_reach_decay", bus2.env_state, 2);
        repeat (4) @(posedge clk);
        #1;
        check("dut2_sustain_state", bus2.env_state, 3);
        check("dut2_sustain_level", bus2.env_level, 255);
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (256) begin @(negedge clk); cnt += int'(bus2.pwmout); end
        check("pwm_duty_255", cnt, 255);

        // Release
        @(posedge clk); #1 bus1.gate = 1'b0;
        push(4, 128); push(4, 96); push(4, 64); push(4, 32); push(0, 0);
        @(posedge clk);
        @(posedge clk); #1 check("release_not_early", bus1.env_state, 3);
        @(posedge clk); #1 check("release_after_2",   bus1.env_state, 4);
        wait1(0, 0, 100, "reach_idle");
        check("idle_active", bus1.active, 0);
        repeat (4) @(negedge clk);
        check("sb_drained_idle", exp_q.size(), 0);
        cnt = 0;
        repeat (256) begin @(negedge clk); cnt += int'(bus1.pwmout); end
        check("pwm_duty_0", cnt, 0);

        // Retrigger during release at 64; the rise lands on a tick cycle
        @(posedge clk); #1 bus1.gate = 1'b1;
        push_note_to_sustain();
        wait1(3, 128, 200, "reach_sustain_2");
        @(posedge clk); #1 bus1.gate = 1'b0;
        push(4, 128); push(4, 96); push(4, 64);
        wait1(4, 64, 100, "reach_release_64");
        @(posedge clk); #1 bus1.gate = 1'b1;
        push(1, 64); push(1, 128);
        @(posedge clk);
        @(posedge clk); #1 check("retrig_not_early", bus1.env_state, 4);
        @(posedge clk); #1;
        check("retrig_state",         bus1.env_state, 1);
        check("collision_level_held", bus1.env_level, 64);
        wait1(1, 128, 20, "attack_resumed_128");

        // Reset mid-attack with gate held high
        push(0, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_level",  bus1.env_level, 0);
        check("midrst_state",  bus1.env_state, 0);
        check("midrst_active", bus1.active, 0);
        check("midrst_pwmout", bus1.pwmout, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus1.env_state != 3'd0) viol++;
        end
        check("held_gate_no_rise", viol, 0);
        check("sb_drained_reset", exp_q.size(), 0);

        @(posedge clk); #1 bus1.gate = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus1.gate = 1'b1;
        push(1, 0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1 check("toggle_attack", bus1.env_state, 1);
        @(negedge clk); #1 mon_en = 1'b0;
        check("sb_drained_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
